// File: rtl/inv_round_mix_stage_pkg.sv
// Shared AES decryptor definitions: constants, round-stage state
// encoding and GF(2^8) helpers built from xtime chains.
package inv_round_mix_stage_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns constants 09/0b/0d/0e.
    function automatic logic [7:0] gf_mul_const(
        input logic [7:0] a,
        input logic [7:0] c
    );
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h09:   r = x8 ^ a;
            8'h0b:   r = x8 ^ x2 ^ a;
            8'h0d:   r = x8 ^ x4 ^ a;
            8'h0e:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_round_mix_stage_if.sv
// Handshake bundle between round controller and the round-mix stage.
// master: drives in_*/out_ready; slave: drives in_ready/out_valid/out_data.
interface inv_round_mix_stage_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/inv_round_mix_stage_inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column (byte 0 = MSB).
// Ports: i_col column in, o_col transformed column out.
import inv_round_mix_stage_pkg::*;

module inv_mix_column (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col[31:24] = gf_mul_const(w_a0, 8'h0e) ^ gf_mul_const(w_a1, 8'h0b)
                        ^ gf_mul_const(w_a2, 8'h0d) ^ gf_mul_const(w_a3, 8'h09);
    assign o_col[23:16] = gf_mul_const(w_a0, 8'h09) ^ gf_mul_const(w_a1, 8'h0e)
                        ^ gf_mul_const(w_a2, 8'h0b) ^ gf_mul_const(w_a3, 8'h0d);
    assign o_col[15:8]  = gf_mul_const(w_a0, 8'h0d) ^ gf_mul_const(w_a1, 8'h09)
                        ^ gf_mul_const(w_a2, 8'h0e) ^ gf_mul_const(w_a3, 8'h0b);
    assign o_col[7:0]   = gf_mul_const(w_a0, 8'h0b) ^ gf_mul_const(w_a1, 8'h0d)
                        ^ gf_mul_const(w_a2, 8'h09) ^ gf_mul_const(w_a3, 8'h0e);

endmodule

// File: rtl/inv_round_mix_stage.sv
// AES-128 decrypt AddRoundKey + column-serial InvMixColumns stage.
// Ports: clk, rst (sync, active-high), bus (slave: in_* / out_* handshakes).
import inv_round_mix_stage_pkg::*;

module inv_round_mix_stage #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_round_mix_stage_if.slave bus
);

    localparam int N = COLS_PER_CYCLE;

    generate
        if (!(N == 1 || N == 2 || N == 4)) begin : g_bad_cols
            $error("COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_t       r_state;
    logic [127:0] r_work;
    logic [127:0] r_out_data;
    logic [1:0]   r_cnt;
    logic         r_out_valid;

    logic [31:0]  w_col_in  [N];
    logic [31:0]  w_col_out [N];
    logic [127:0] w_next;
    logic         w_last_col;
    logic [127:0] w_keyed;

    assign w_keyed = bus.in_data ^ bus.in_key;

    // Counter always advances in steps of N, so cnt+k never passes column 3.
    always_comb begin
        w_next = r_work;
        for (int k = 0; k < N; k++) begin
            w_col_in[k] = '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                if (({1'b0, r_cnt} + 3'(k)) == 3'(c)) begin
                    w_col_in[k] = r_work[127-32*c -: 32];
                end
            end
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int k = 0; k < N; k++) begin
                if (({1'b0, r_cnt} + 3'(k)) == 3'(c)) begin
                    w_next[127-32*c -: 32] = w_col_out[k];
                end
            end
        end
    end

    assign w_last_col = (({1'b0, r_cnt} + 3'(N)) == 3'd4);

    generate
        for (genvar k = 0; k < N; k++) begin : g_col
            inv_mix_column u_imc (
                .i_col (w_col_in[k]),
                .o_col (w_col_out[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_out_data  <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_work <= w_keyed;
                        r_cnt  <= '0;
                        if (bus.in_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_keyed;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_work <= w_next;
                    if (w_last_col) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_next;
                    end else begin
                        r_cnt <= r_cnt + 2'(N);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Depends on state and reset only, never on in_valid or out_ready.
    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_inv_round_mix_stage.sv
// Self-checking bench: three DUTs (N=1,2,4) in lockstep on shared stimulus.
// Directed vector table, stall/ignore, mid-run reset and random blocks.
module tb_inv_round_mix_stage;

    localparam int NS [3] = '{1, 2, 4};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_last;
    logic         out_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;

    logic         ov [3];
    logic         ir [3];
    logic [127:0] od [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inv_round_mix_stage_if ifs [3] ();

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            assign ifs[g].in_valid  = in_valid;
            assign ifs[g].in_data   = in_data;
            assign ifs[g].in_key    = in_key;
            assign ifs[g].in_last   = in_last;
            assign ifs[g].out_ready = out_ready;
            assign ov[g] = ifs[g].out_valid;
            assign ir[g] = ifs[g].in_ready;
            assign od[g] = ifs[g].out_data;

            inv_round_mix_stage #(.COLS_PER_CYCLE(NS[g])) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (ifs[g].slave)
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Independent reference: shift-and-add GF multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] d,
                                               input logic [127:0] k,
                                               input logic last);
        logic [127:0] s = d ^ k;
        logic [127:0] r = s;
        logic [7:0] a [4];
        logic [7:0] m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        if (last) return s;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                logic [7:0] b = 8'h00;
                for (int j = 0; j < 4; j++) b ^= gmul(a[j], m[(j - i + 4) % 4]);
                r[127-32*c-8*i -: 8] = b;
            end
        end
        return r;
    endfunction

    // One block through all three DUTs; handshake after all are valid + stall.
    task automatic run_block(input logic [127:0] d, input logic [127:0] k,
                             input logic last, input logic [127:0] exp,
                             input int stall, input string nm);
        int lat [3];
        logic [127:0] cap [3];
        bit irbad;
        bit unstable;
        bit alldone;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk({nm, " in_ready idle"}, 128'(ir[i]), 128'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_last  = ~last;
        lat = '{0, 0, 0};
        irbad = 1'b0;
        unstable = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            alldone = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (ir[i]) irbad = 1'b1;
                if (lat[i] != 0 && (!ov[i] || od[i] !== cap[i])) unstable = 1'b1;
                if (ov[i] && lat[i] == 0) begin
                    lat[i] = cyc;
                    cap[i] = od[i];
                end
                if (lat[i] == 0) alldone = 1'b0;
            end
            if (alldone) break;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ir[i]) irbad = 1'b1;
                if (!ov[i] || od[i] !== cap[i]) unstable = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s latency N=%0d", nm, NS[i]), 128'(lat[i]),
                128'(last ? 1 : 1 + 4 / NS[i]));
            chk($sformatf("%s data N=%0d", nm, NS[i]), cap[i], exp);
        end
        chk({nm, " in_ready low while busy"}, 128'(irbad), 128'd0);
        chk({nm, " output stable"}, 128'(unstable), 128'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk({nm, " out_valid drop"}, 128'(ov[i]), 128'd0);
            chk({nm, " in_ready after"}, 128'(ir[i]), 128'd1);
        end
    endtask

    initial begin
        logic [127:0] kx;
        logic [127:0] rd;
        logic [127:0] rk;
        logic         rl;
        kx = 128'h01234567_89abcdef_fedcba98_76543210;
        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0,
                    128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{128'h0, {128{1'b1}}, 1'b1, {128{1'b1}}};
        vecs[2] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b1,
                    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[3] = '{128'h0, 128'h0, 1'b0, 128'h0};
        vecs[4] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 ^ kx, kx, 1'b0,
                    128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[5] = '{{128{1'b1}}, 128'h0, 1'b0, {128{1'b1}}};
        vecs[6] = '{128'hc6c6c6c6_8e4da1bc_d4d4d4d4_9fdc589d, 128'h0, 1'b0,
                    128'hc6c6c6c6_db135345_d4d4d4d4_f20a225c};
        vecs[7] = '{128'h4d7ebdf8_01010101_8e4da1bc_c6c6c6c6, 128'h0, 1'b0,
                    128'h2d26314c_01010101_db135345_c6c6c6c6};

        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("in_ready in reset", 128'(ir[i]), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset out_valid", 128'(ov[i]), 128'd0);
            chk("reset out_data", od[i], 128'd0);
            chk("reset in_ready", 128'(ir[i]), 128'd1);
        end

        for (int v = 0; v < 8; v++) begin
            run_block(vecs[v].data, vecs[v].key, vecs[v].last, vecs[v].exp,
                      (v == 0) ? 3 : v % 3, $sformatf("vec%0d", v));
        end

        // in_valid pulses while busy/done must not be taken.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vecs[6].data;
        in_key   = 128'h0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            in_valid = cyc[0];
            in_data  = {4{32'hdeadbeef}} ^ 128'(cyc);
            in_last  = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk("ignore in_ready", 128'(ir[i]), 128'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("ignore data", od[i], vecs[6].exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk("no phantom block", 128'(ov[i]), 128'd0);
        end

        // Reset in the second BUSY cycle aborts the block.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vecs[0].data;
        in_key   = vecs[0].key;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("abort in_ready", 128'(ir[i]), 128'd1);
            chk("abort out_valid", 128'(ov[i]), 128'd0);
            chk("abort out_data", od[i], 128'd0);
        end
        run_block(vecs[0].data, vecs[0].key, 1'b0, vecs[0].exp, 0, "post_abort");

        for (int n = 0; n < 20; n++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            rl = 1'($urandom_range(0, 1));
            run_block(rd, rk, rl, ref_round(rd, rk, rl), $urandom_range(0, 2),
                      $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_round_mix_stage.md
# inv_round_mix_stage

Iterative AddRoundKey + InvMixColumns stage of the AES-128 decryptor. It sits directly downstream of the combinational inverse S-box layer and consumes that layer's 128-bit output together with the current round key. It XORs the key in, then runs InvMixColumns column-serially over several cycles, or skips it for the final round. Valid/ready handshakes on both sides let the round controller stall it.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream block valid
- in_ready  output  1  stage can accept; high only in IDLE and not in reset
- in_data  input  128  state after inverse S-box layer; byte 0 = bits [127:120], column c = bits [127-32c -: 32]
- in_key  input  128  round key, same byte order
- in_last  input  1  final round: AddRoundKey only, no InvMixColumns
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  128  round result

## Operation
- States: IDLE, BUSY, DONE. Reset goes to IDLE with out_valid=0, out_data=0, column counter=0, working register=0.
- IDLE: in_ready=1. On in_valid&in_ready, the working register loads in_data^in_key, and in_last is latched.
  - If latched last=1, go to DONE.
  - Otherwise, go to BUSY with the column counter at 0.
- BUSY: each cycle, replace columns counter..counter+N-1 (N=COLS_PER_CYCLE) of the working register with their InvMixColumns result, then add N to the counter.
  - When the updated columns include column 3, go to DONE and clear the counter.
  - in_valid is ignored; in_ready=0.
- DONE: out_valid=1 and out_data = working register. Hold both until out_ready.
  - On out_valid&out_ready, go to IDLE and drop out_valid.
  - No new input is accepted in the same cycle.
- InvMixColumns for column bytes a0..a3 (a0 = MSB byte):
  - b0=0e·a0^0b·a1^0d·a2^09·a3
  - b1=09·a0^0e·a1^0b·a2^0d·a3
  - b2=0d·a0^09·a1^0e·a2^0b·a3
  - b3=0b·a0^0d·a1^09·a2^0e·a3
- Multiplication is in GF(2^8), reduction polynomial 0x11B, built from xtime chains (no tables). All results are 8-bit; no carries.
- out_data changes only on the transition into DONE; it is stable while out_valid=1 and out_ready=0.
- rst in any state aborts the block: next cycle is IDLE with the reset values, and the partial result is discarded.
- Illegal COLS_PER_CYCLE is a compile-time error (generate-time check).

## Timing
- Accept edge = cycle 0.
- Final round (in_last=1): out_valid high in cycle 1.
- Normal round: BUSY occupies cycles 1..4/N; out_valid high in cycle 1+4/N (5 for N=1, 3 for N=2, 2 for N=4).
- Throughput with out_ready tied high: one block every 2+4/N cycles (normal) or every 2 cycles (last).
- in_ready is combinational from state only, never from in_valid. There is no combinational path from out_ready to in_ready in the same cycle.

## Structure
- Shared decryptor package holds:
  - AES_POLY = 8'h1B
  - NUM_COLS = 4
  - the state enum (IDLE, BUSY, DONE)
  - xtime and gf_mul_const functions for constants 09/0b/0d/0e
- Sub-module inv_mix_column: combinational 32-bit column in -> 32-bit column out. Instantiate N copies; the column mux is indexed by the counter.

## Test plan
- in_key=0, in_last=0, in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, N=1 -> out_data=db135345_f20a225c_01010101_c6c6c6c6, out_valid first high in cycle 5, in_ready low cycles 1..5.
- in_data=0, in_key=all ff, in_last=1 -> out_data=all ff in cycle 1, no BUSY cycles.
- Repeat scenario 1 with N=2 and N=4 -> same out_data, out_valid in cycle 3 and cycle 2 respectively.
- out_ready low for 3 cycles after out_valid -> out_data/out_valid stable, in_ready=0. in_valid pulses during BUSY/DONE are ignored; the next block is accepted only after the out handshake plus one IDLE cycle.
- rst asserted in cycle 2 of BUSY -> cycle after rst: state IDLE, in_ready=1, out_valid=0, out_data=0. A new block then produces the correct result with nominal latency.
- Randomized back-to-back blocks with random in_last and out_ready -> every result matches a reference InvMixColumns(in_data^in_key), or in_data^in_key when in_last=1, in order, with no drops or duplicates.
